line_fill_master: RTL and testbench
===================================

# line_fill_master

Bus initiator for the 30-bit word-addressed memory bus with waitrequest and ID-tagged burst read returns, the bus the SRAM controller serves. Accepts one client request at a time (cache-line fill or single-word store), drives mem_read/mem_write until accepted, collects the ID-tagged read burst and presents the whole line to the client. Sits between the data cache and the memory arbiter or SRAM controller.

## Interface
- burst_bits, 2: log2 words per line; burst_length = 1 << burst_bits.
- my_id, 2'd1: bus ID driven on reads; must be nonzero, because ID 0 means no data.
- timeout_cycles, 255: max cycles in S_READDATA (only with LINE_FILL_TIMEOUT_EN).
- Reset: one clock; reset is synchronous and active-high.
- clock  in  1  sole clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  client request present.
- req_ready  out  1  high only in S_IDLE.
- req_write  in  1  1 = store word, 0 = line fill.
- req_address  in  30  word address.
- req_writedata  in  32  store data.
- req_writemask  in  4  byte enables, 1 = write byte.
- fill_valid  out  1  one-cycle pulse, line complete.
- fill_address  out  30  line-aligned address of the delivered line.
- fill_line  out  32*burst_length  word i at bits [32*i+31:32*i].
- err  out  1  one-cycle timeout pulse; constant 0 without the macro.
- mem_waitrequest  in  1  bus stall.
- mem_id  out  2  request ID.
- mem_address  out  30  word address.
- mem_read  out  1  burst read request.
- mem_write  out  1  write request.
- mem_writedata  out  32  write data.
- mem_writedatamask  out  4  byte enables.
- mem_readdata  in  32  returned word.
- mem_readdataid  in  2  ID of the returned word; 0 = none.

## Operation
- States: S_IDLE, S_READREQ, S_READDATA, S_WRITEREQ.
- S_IDLE: on req_valid, latch the request.
  - Fill: mem_address = {req_address[29:burst_bits], 0}, mem_id = my_id, mem_read = 1, go to S_READREQ.
  - Store: mem_address = req_address, drive data and mask, mem_write = 1, go to S_WRITEREQ.
- S_READREQ: hold every mem_* output stable while mem_waitrequest = 1. On a posedge with mem_waitrequest = 0, drop mem_read, clear cnt, go to S_READDATA.
- S_READDATA: on each posedge with mem_readdataid == my_id, store mem_readdata into word cnt and increment cnt.
  - When the burst_length-th word is stored: pulse fill_valid next cycle and return to S_IDLE.
  - Words tagged with another nonzero ID are ignored.
- S_WRITEREQ: hold outputs until mem_waitrequest = 0 at a posedge, then drop mem_write and return to S_IDLE. A store is complete once the bus accepts it; there is no ack.
- mem_read and mem_write are never high together.
- cnt is burst_bits+1 wide and never wraps within a burst.
- Reset mid-operation: return to S_IDLE immediately. Late words tagged my_id arriving in S_IDLE are dropped.

## Timing
- Reset values: req_ready 1, mem_read 0, mem_write 0, mem_id 0, mem_address 0, mem_writedata 0, mem_writedatamask 0, fill_valid 0, fill_address 0, fill_line 0, err 0.
- All mem_* outputs are registered. A request accepted at posedge N drives the bus from cycle N+1.
- Zero-wait bus: bus accept at N+1 gives S_READDATA from N+2.
- fill_valid rises the cycle after the last word is captured. req_ready is high in that same cycle.
- fill_line and fill_address stay stable until the next fill completes.
- A word tagged my_id in the same cycle as bus acceptance (S_READREQ) is captured as word 0.
- Minimum turnaround: a new request can be accepted in the fill_valid cycle.

## Configuration
- LINE_FILL_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter runs in S_READDATA and reloads whenever a my_id word arrives.
  - On reaching timeout_cycles, pulse err, go to S_IDLE, and do not assert fill_valid.
- Undefined: no counter; S_READDATA waits indefinitely; err tied 0.

## Structure
- Shared package mem_bus_pkg: address width 30, data width 32, ID width 2, state encoding constants. The SRAM controller uses the same constants.
- One natural sub-module, burst_collector: cnt, the word registers, and the line-complete flag. Driven by a capture strobe and the data; outputs the full line and done.

## Test plan
- Fill at req_address 0x0000_0045, zero-wait bus returning 0xA0..0xA3 tagged 1 -> mem_address 0x44, fill_address 0x44, fill_line = {A3,A2,A1,A0}, one fill_valid pulse.
- Waitrequest held 3 cycles on a fill -> mem_read, mem_address and mem_id stable for all 4 cycles; exactly one bus accept.
- Store 0xDEADBEEF, mask 4'b0011, with waitrequest held 2 cycles -> mem_write high 3 cycles, mask 0011, back to S_IDLE, no fill_valid.
- Fill with interleaved returns tagged 2 (0xBAD) among 4 returns tagged 1 -> only the ID-1 words appear in fill_line.
- rst during S_READDATA after 2 words, then 2 late ID-1 words -> outputs at reset values, no fill_valid, idle.
- With LINE_FILL_TIMEOUT_EN and timeout_cycles 8: only 3 words returned -> err pulse 8 cycles after the last word, no fill_valid, req_ready high.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared constants for the 30-bit word-addressed memory bus with ID-tagged burst reads.
// The SRAM controller imports the same widths and state encodings.
package mem_bus_pkg;
  localparam int ADDR_W  = 30;
  localparam int DATA_W  = 32;
  localparam int ID_W    = 2;
  localparam int MASK_W  = DATA_W / 8;
  localparam int STATE_W = 2;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ID_W-1:0]   id_t;
  typedef logic [MASK_W-1:0] mask_t;

  localparam logic [STATE_W-1:0] S_IDLE     = 2'd0;
  localparam logic [STATE_W-1:0] S_READREQ  = 2'd1;
  localparam logic [STATE_W-1:0] S_READDATA = 2'd2;
  localparam logic [STATE_W-1:0] S_WRITEREQ = 2'd3;

  // First word address of the line containing a.
  function automatic addr_t line_align(input addr_t a, input int bits);
    return (a >> bits) << bits;
  endfunction
endpackage

// File: rtl/line_fill_master_if.sv
// Client request / line delivery and memory-bus signals of line_fill_master.
// master = the line fill initiator, slave = client plus memory side.
interface line_fill_master_if
  import mem_bus_pkg::*;
#(
  parameter int burst_bits = 2
);
  localparam int LINE_W = DATA_W << burst_bits;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  addr_t             req_address;
  data_t             req_writedata;
  mask_t             req_writemask;
  logic              fill_valid;
  addr_t             fill_address;
  logic [LINE_W-1:0] fill_line;
  logic              err;
  logic              mem_waitrequest;
  id_t               mem_id;
  addr_t             mem_address;
  logic              mem_read;
  logic              mem_write;
  data_t             mem_writedata;
  mask_t             mem_writedatamask;
  data_t             mem_readdata;
  id_t               mem_readdataid;

  modport master (
    input  req_valid, req_write, req_address, req_writedata, req_writemask,
           mem_waitrequest, mem_readdata, mem_readdataid,
    output req_ready, fill_valid, fill_address, fill_line, err,
           mem_id, mem_address, mem_read, mem_write, mem_writedata, mem_writedatamask
  );

  modport slave (
    output req_valid, req_write, req_address, req_writedata, req_writemask,
           mem_waitrequest, mem_readdata, mem_readdataid,
    input  req_ready, fill_valid, fill_address, fill_line, err,
           mem_id, mem_address, mem_read, mem_write, mem_writedata, mem_writedatamask
  );
endinterface

// File: rtl/line_fill_master_burst_collector.sv
// Gathers the ID-matched words of one read burst and publishes the completed line.
// line_data holds the last completed line until the next burst finishes.
module burst_collector
  import mem_bus_pkg::*;
#(
  parameter int burst_bits = 2
) (
  input  logic                              clock,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              capture,
  input  data_t                             data,
  output logic [(DATA_W << burst_bits)-1:0] line_data,
  output logic                              done,
  output logic                              last_word
);
  localparam int LEN    = 1 << burst_bits;
  localparam int LINE_W = DATA_W * LEN;
  localparam logic [burst_bits:0] LAST_IDX = (burst_bits + 1)'(LEN - 1);

  logic [burst_bits:0] cnt;
  logic [burst_bits:0] idx;
  logic [LINE_W-1:0]   stage;
  logic [LINE_W-1:0]   line_next;

  // A word arriving on the bus-accept cycle lands in slot 0 of the fresh burst.
  always_comb begin
    // NOTE: every variable gets a value on every path first, so no latch is inferred.
    idx       = clear ? '0 : cnt;
    line_next = stage;
    line_next[idx[burst_bits-1:0]*DATA_W +: DATA_W] = data;
    last_word = capture && (idx == LAST_IDX);
  end

  // NOTE: the staging words need no reset; each slot is written before the line is published.
  always_ff @(posedge clock) begin
    if (capture) stage <= line_next;
  end

  // NOTE: sequential state always uses non-blocking assignments.
  always_ff @(posedge clock) begin
    if (rst) begin
      cnt       <= '0;
      line_data <= '0;
      done      <= 1'b0;
    end else begin
      done <= last_word;
      if (capture)    cnt <= idx + 1'b1;
      else if (clear) cnt <= '0;
      if (last_word) line_data <= line_next;
    end
  end
endmodule

// File: rtl/line_fill_master.sv
// Memory-bus initiator: one cache-line burst fill or single-word store at a time.
// Optional LINE_FILL_TIMEOUT_EN aborts a stalled burst with an err pulse.
module line_fill_master
  import mem_bus_pkg::*;
#(
  parameter int        burst_bits     = 2,
  parameter logic [ID_W-1:0] my_id    = 2'd1,
  parameter int        timeout_cycles = 255
) (
  input logic                clock,
  input logic                rst,
  line_fill_master_if.master bus
);
  localparam int LINE_W = DATA_W << burst_bits;

  logic [STATE_W-1:0] state;
  logic               mem_read_q;
  logic               mem_write_q;
  id_t                mem_id_q;
  addr_t              mem_address_q;
  data_t              mem_writedata_q;
  mask_t              mem_mask_q;
  addr_t              fill_address_q;
  logic               accept;
  logic               capture;
  logic               last_word;
  logic               fill_done;
  logic               timeout_hit;
  logic [LINE_W-1:0]  line_data;

  assign accept  = (state == S_READREQ) && !bus.mem_waitrequest;
  assign capture = (bus.mem_readdataid == my_id) && (accept || state == S_READDATA);

  burst_collector #(.burst_bits(burst_bits)) u_collector (
    .clock     (clock),
    .rst       (rst),
    .clear     (accept),
    .capture   (capture),
    .data      (bus.mem_readdata),
    .line_data (line_data),
    .done      (fill_done),
    .last_word (last_word)
  );

`ifdef LINE_FILL_TIMEOUT_EN
  localparam int TMO_W = ($clog2(timeout_cycles + 1) > 8) ? $clog2(timeout_cycles + 1) : 8;
  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  // Counts idle cycles since the last matching word; fires when the next cycle would reach the limit.
  assign timeout_hit = (state == S_READDATA) && !capture &&
                       (tmo_cnt == TMO_W'(timeout_cycles - 1));

  always_ff @(posedge clock) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if (state != S_READDATA || capture) tmo_cnt <= '0;
      else                                tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
  assign bus.err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus.err     = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (rst) begin
      state           <= S_IDLE;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_id_q        <= '0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      mem_mask_q      <= '0;
      fill_address_q  <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.req_valid) begin
          if (bus.req_write) begin
            mem_address_q   <= bus.req_address;
            mem_writedata_q <= bus.req_writedata;
            mem_mask_q      <= bus.req_writemask;
            mem_write_q     <= 1'b1;
            state           <= S_WRITEREQ;
          end else begin
            mem_address_q <= line_align(bus.req_address, burst_bits);
            mem_id_q      <= my_id;
            mem_read_q    <= 1'b1;
            state         <= S_READREQ;
          end
        end
        S_READREQ: if (accept) begin
          mem_read_q <= 1'b0;
          state      <= last_word ? S_IDLE : S_READDATA;
        end
        S_READDATA: begin
          if (last_word || timeout_hit) state <= S_IDLE;
        end
        S_WRITEREQ: if (!bus.mem_waitrequest) begin
          mem_write_q <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // mem_address still holds the line address while the burst is in flight.
      if (last_word) fill_address_q <= mem_address_q;
    end
  end

  assign bus.req_ready         = (state == S_IDLE);
  assign bus.fill_valid        = fill_done;
  assign bus.fill_address      = fill_address_q;
  assign bus.fill_line         = line_data;
  assign bus.mem_id            = mem_id_q;
  assign bus.mem_address       = mem_address_q;
  assign bus.mem_read          = mem_read_q;
  assign bus.mem_write         = mem_write_q;
  assign bus.mem_writedata     = mem_writedata_q;
  assign bus.mem_writedatamask = mem_mask_q;
endmodule

// File: tb/tb_line_fill_master.sv
// Bench for line_fill_master: vector table of fills/stores with a fill scoreboard,
// plus reset-during-burst and (with LINE_FILL_TIMEOUT_EN) timeout sequences.
module tb_line_fill_master;
  import mem_bus_pkg::*;

  localparam int BB     = 2;
  localparam int LEN    = 1 << BB;
  localparam int LINE_W = DATA_W * LEN;
  localparam int TMO    = 8;

  typedef logic [LINE_W-1:0] val_t;

  typedef struct {
    bit    write;
    addr_t addr;
    data_t data;     // store data, or base of the returned words for a fill
    mask_t mask;
    int    wait_n;
    bit    early;    // first word returned in the bus-accept cycle
    bit    noise;    // foreign-ID word before each returned word
    addr_t exp_addr;
    val_t  exp_line;
  } vec_t;

  typedef struct {
    addr_t addr;
    val_t  line;
  } exp_t;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  line_fill_master_if #(.burst_bits(BB)) bus ();

  line_fill_master #(.burst_bits(BB), .my_id(2'd1), .timeout_cycles(TMO)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus.master)
  );

  exp_t exp_q[$];
  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;
  int   fills_seen = 0;
  int   fills_expected = 0;

  task automatic check(input string name, input val_t act, input val_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic val_t line_of(input data_t base);
    val_t l;
    for (int i = 0; i < LEN; i++) l[i*DATA_W +: DATA_W] = base + data_t'(i);
    return l;
  endfunction

  task automatic idle_bus();
    bus.mem_readdataid = 2'd0;
    bus.mem_readdata   = 32'hFFFF_FFFF;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"},    val_t'(bus.req_ready), val_t'(1));
    check({tag, "_mem_read"},     val_t'(bus.mem_read), val_t'(0));
    check({tag, "_mem_write"},    val_t'(bus.mem_write), val_t'(0));
    check({tag, "_mem_id"},       val_t'(bus.mem_id), val_t'(0));
    check({tag, "_mem_address"},  val_t'(bus.mem_address), val_t'(0));
    check({tag, "_mem_wdata"},    val_t'(bus.mem_writedata), val_t'(0));
    check({tag, "_mem_mask"},     val_t'(bus.mem_writedatamask), val_t'(0));
    check({tag, "_fill_valid"},   val_t'(bus.fill_valid), val_t'(0));
    check({tag, "_fill_address"}, val_t'(bus.fill_address), val_t'(0));
    check({tag, "_fill_line"},    bus.fill_line, val_t'(0));
    check({tag, "_err"},          val_t'(bus.err), val_t'(0));
  endtask

  // Drives one vector from the first idle negedge; returns at the negedge where fill_valid is due.
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    check({tag, "_ready_before"}, val_t'(bus.req_ready), val_t'(1));
    bus.req_valid     = 1'b1;
    bus.req_write     = v.write;
    bus.req_address   = v.addr;
    bus.req_writedata = v.data;
    bus.req_writemask = v.mask;
    if (!v.write) begin
      exp_q.push_back('{addr: v.exp_addr, line: v.exp_line});
      fills_expected++;
    end
    @(negedge clock);
    bus.req_valid = 1'b0;
    for (int k = 0; k <= v.wait_n; k++) begin
      check({tag, "_mem_address"}, val_t'(bus.mem_address), val_t'(v.exp_addr));
      check({tag, "_ready_busy"}, val_t'(bus.req_ready), val_t'(0));
      if (v.write) begin
        check({tag, "_mem_write"}, val_t'(bus.mem_write), val_t'(1));
        check({tag, "_mem_wdata"}, val_t'(bus.mem_writedata), val_t'(v.data));
        check({tag, "_mem_mask"},  val_t'(bus.mem_writedatamask), val_t'(v.mask));
      end else begin
        check({tag, "_mem_read"}, val_t'(bus.mem_read), val_t'(1));
        check({tag, "_mem_id"},   val_t'(bus.mem_id), val_t'(1));
      end
      bus.mem_waitrequest = (k < v.wait_n);
      if (k == v.wait_n && v.early) begin
        bus.mem_readdataid = 2'd1;
        bus.mem_readdata   = v.data;
      end
      @(negedge clock);
    end
    bus.mem_waitrequest = 1'b0;
    idle_bus();
    if (v.write) begin
      check({tag, "_write_dropped"}, val_t'(bus.mem_write), val_t'(0));
      check({tag, "_ready_after"},   val_t'(bus.req_ready), val_t'(1));
      check({tag, "_no_fill"},       val_t'(bus.fill_valid), val_t'(0));
      return;
    end
    check({tag, "_read_dropped"}, val_t'(bus.mem_read), val_t'(0));
    for (int i = v.early ? 1 : 0; i < LEN; i++) begin
      if (v.noise) begin
        bus.mem_readdataid = 2'd2;
        bus.mem_readdata   = 32'h0000_0BAD;
        @(negedge clock);
      end
      bus.mem_readdataid = 2'd1;
      bus.mem_readdata   = v.data + data_t'(i);
      @(negedge clock);
    end
    idle_bus();
    check({tag, "_fill_valid"},  val_t'(bus.fill_valid), val_t'(1));
    check({tag, "_ready_fill"},  val_t'(bus.req_ready), val_t'(1));
  endtask

  // Scoreboard side: every fill_valid pulse consumes one expected line.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (!rst) begin
      check("rd_wr_exclusive", val_t'(bus.mem_read & bus.mem_write), val_t'(0));
      if (bus.fill_valid) begin
        fills_seen++;
        check("fill_expected_pending", val_t'(exp_q.size() != 0), val_t'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("fill_address", val_t'(bus.fill_address), val_t'(e.addr));
          check("fill_line", bus.fill_line, e.line);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "bench timed out");
  end

  initial begin
    vecs[0] = '{write: 1'b0, addr: 30'h45, data: 32'hA0, mask: 4'h0, wait_n: 0,
                early: 1'b0, noise: 1'b0, exp_addr: 30'h44, exp_line: line_of(32'hA0)};
    vecs[1] = '{write: 1'b0, addr: 30'h123_4567, data: 32'h1000, mask: 4'h0, wait_n: 3,
                early: 1'b0, noise: 1'b0, exp_addr: 30'h123_4564, exp_line: line_of(32'h1000)};
    vecs[2] = '{write: 1'b1, addr: 30'h0A_BCDE, data: 32'hDEAD_BEEF, mask: 4'b0011, wait_n: 2,
                early: 1'b0, noise: 1'b0, exp_addr: 30'h0A_BCDE, exp_line: '0};
    vecs[3] = '{write: 1'b0, addr: 30'h3FFF_FFFF, data: 32'hC0DE_0000, mask: 4'h0, wait_n: 0,
                early: 1'b0, noise: 1'b1, exp_addr: 30'h3FFF_FFFC, exp_line: line_of(32'hC0DE_0000)};
    vecs[4] = '{write: 1'b0, addr: 30'h8, data: 32'h55, mask: 4'h0, wait_n: 1,
                early: 1'b1, noise: 1'b0, exp_addr: 30'h8, exp_line: line_of(32'h55)};
    vecs[5] = '{write: 1'b1, addr: 30'h3FFF_FFFF, data: 32'h1234_5678, mask: 4'hF, wait_n: 0,
                early: 1'b0, noise: 1'b0, exp_addr: 30'h3FFF_FFFF, exp_line: '0};
    vecs[6] = '{write: 1'b0, addr: 30'h2000_0003, data: 32'hFFFF_FFFE, mask: 4'h0, wait_n: 0,
                early: 1'b1, noise: 1'b1, exp_addr: 30'h2000_0000, exp_line: line_of(32'hFFFF_FFFE)};

    bus.req_valid       = 1'b0;
    bus.req_write       = 1'b0;
    bus.req_address     = '0;
    bus.req_writedata   = '0;
    bus.req_writemask   = '0;
    bus.mem_waitrequest = 1'b0;
    idle_bus();
    repeat (2) @(negedge clock);
    rst = 1'b0;
    check_reset_values("reset");

    // Back-to-back: each vector starts in the fill_valid cycle of the previous one.
    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);
    @(negedge clock);

    // Reset after two words of a burst, then late words carrying our ID.
    bus.req_valid   = 1'b1;
    bus.req_write   = 1'b0;
    bus.req_address = 30'h100;
    @(negedge clock);
    bus.req_valid = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      bus.mem_readdataid = 2'd1;
      bus.mem_readdata   = 32'h7700 + data_t'(i);
      @(negedge clock);
    end
    rst = 1'b1;
    idle_bus();
    @(negedge clock);
    rst = 1'b0;
    check_reset_values("midrst");
    for (int i = 0; i < 2; i++) begin
      bus.mem_readdataid = 2'd1;
      bus.mem_readdata   = 32'h7702 + data_t'(i);
      @(negedge clock);
      check("late_word_no_fill", val_t'(bus.fill_valid), val_t'(0));
      check("late_word_idle", val_t'(bus.req_ready), val_t'(1));
    end
    idle_bus();
    @(negedge clock);
    check("late_word_line", bus.fill_line, val_t'(0));

`ifdef LINE_FILL_TIMEOUT_EN
    // Three of four words arrive; err must pulse TMO cycles after the last one.
    bus.req_valid   = 1'b1;
    bus.req_address = 30'h200;
    @(negedge clock);
    bus.req_valid = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      bus.mem_readdataid = 2'd1;
      bus.mem_readdata   = 32'h9900 + data_t'(i);
      @(negedge clock);
    end
    idle_bus();
    for (int k = 1; k < TMO; k++) begin
      check("tmo_err_early", val_t'(bus.err), val_t'(0));
      @(negedge clock);
    end
    check("tmo_err_early", val_t'(bus.err), val_t'(0));
    @(negedge clock);
    check("tmo_err_pulse", val_t'(bus.err), val_t'(1));
    check("tmo_no_fill", val_t'(bus.fill_valid), val_t'(0));
    check("tmo_ready", val_t'(bus.req_ready), val_t'(1));
    @(negedge clock);
    check("tmo_err_one_cycle", val_t'(bus.err), val_t'(0));
`else
    check("err_tied_low", val_t'(bus.err), val_t'(0));
`endif

    repeat (3) @(negedge clock);
    check("fill_count", val_t'(fills_seen), val_t'(fills_expected));
    check("scoreboard_empty", val_t'(exp_q.size()), val_t'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
